number_slot_manager: RTL and testbench

Parametrised manager for the rope-mounted collectible digits. It owns the per-slot lifecycle of SLOTS digits: visible, hidden after a hit, re-spawned with a fresh pseudo-random value, then briefly flashing. It sums the values of collected digits for the score block and merges the per-slot draw requests from the NUMBER_DISPLAY instances into one draw request and one colour for the VGA mux.

---
 rtl/number_slot_pkg.sv | 51 +++++
 rtl/number_slot_ctrl.sv | 119 +++++++++++
 rtl/number_slot_manager.sv | 132 +++++++++++++
 tb/tb_number_slot_manager.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/number_slot_pkg.sv
// -----------------------------------------------------------------------------
// number_slot_pkg
// Shared types, constants and helpers for the collectible-digit slot manager.
//   slot_state_t    : per-slot lifecycle state
//   digit_t         : 4-bit digit value
//   LFSR_TAPS       : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   TRANSPARENT_RGB : colour driven when no slot requests drawing
//   rotl8()         : 8-bit rotate-left, used to decorrelate simultaneous re-spawns
//   lfsr_to_digit() : folds a raw LFSR nibble into the range 1..dmax
// -----------------------------------------------------------------------------
package number_slot_pkg;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        HIDDEN  = 2'd1,
        FLASH   = 2'd2,
        DEAD    = 2'd3
    } slot_state_t;

    typedef logic [3:0] digit_t;

    localparam logic [7:0] LFSR_TAPS       = 8'hB8;
    localparam logic [7:0] TRANSPARENT_RGB = 8'hFF;
    localparam int         FRAME_CNT_W     = 4;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] amt);
        logic [7:0] r;
        logic [2:0] idx;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            idx    = 3'(b) + amt;
            r[idx] = x[b];
        end
        return r;
    endfunction

    // A single conditional subtract, then 0 is promoted to 1 so a slot never
    // shows a worthless digit.
    function automatic digit_t lfsr_to_digit(input logic [7:0] x, input int dmax);
        logic [4:0] v;
        v = {1'b0, x[3:0]};
        if (int'(v) > dmax) begin
            v = v - 5'(dmax + 1);
        end
        if (v == 5'd0) begin
            v = 5'd1;
        end
        return v[3:0];
    endfunction

endpackage

// File: rtl/number_slot_ctrl.sv
// -----------------------------------------------------------------------------
// number_slot_ctrl
// Lifecycle controller for one digit slot.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   VISIBLE | digit drawn, hits accepted
//   HIDDEN  | collected, waiting out the timeout, hits ignored
//   FLASH   | re-spawned, blinking with the frame bit, hits accepted
//   DEAD    | one-shot mode, collected for good until reset
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   enable_i           low freezes the timer and drops hits
//   start_of_frame_i   one-clk frame pulse, timer decrements on it
//   hit_i              collision with this slot (level or pulse)
//   flash_bit_i        shared blink phase used while in FLASH
//   cand_digit_i       digit latched on re-spawn
//   show_o             slot is to be drawn
//   collect_o          hit accepted this cycle
//   value_o            current digit (pre-hit value while collect_o is high)
// -----------------------------------------------------------------------------
module number_slot_ctrl
    import number_slot_pkg::*;
#(
    parameter int         TIMEOUT_FRAMES = 450,
    parameter int         FLASH_FRAMES   = 64,
    parameter int         TIMER_W        = 9,
    parameter int         ONE_SHOT       = 0,
    parameter logic [3:0] RESET_DIGIT    = 4'd1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       start_of_frame_i,
    input  logic       hit_i,
    input  logic       flash_bit_i,
    input  logic [3:0] cand_digit_i,
    output logic       show_o,
    output logic       collect_o,
    output logic [3:0] value_o
);

    slot_state_t        state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [3:0]         digit_q;

    logic frame_tick;
    logic terminal;

    assign frame_tick = enable_i & start_of_frame_i;
    // Terminal count is the 1 -> 0 step, so the transition happens on the
    // frame edge itself rather than one frame later.
    assign terminal   = (timer_q <= TIMER_W'(1));
    assign collect_o  = enable_i & hit_i & ((state_q == VISIBLE) | (state_q == FLASH));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= VISIBLE;
            timer_q <= '0;
            digit_q <= RESET_DIGIT;
        end else begin
            case (state_q)
                VISIBLE: begin
                    if (collect_o) begin
                        state_q <= HIDDEN;
                        timer_q <= TIMER_W'(TIMEOUT_FRAMES);
                    end
                end
                HIDDEN: begin
                    if (frame_tick) begin
                        if (terminal) begin
                            if (ONE_SHOT != 0) begin
                                state_q <= DEAD;
                                timer_q <= '0;
                            end else begin
                                digit_q <= cand_digit_i;
                                if (FLASH_FRAMES == 0) begin
                                    state_q <= VISIBLE;
                                    timer_q <= '0;
                                end else begin
                                    state_q <= FLASH;
                                    timer_q <= TIMER_W'(FLASH_FRAMES);
                                end
                            end
                        end else begin
                            timer_q <= timer_q - TIMER_W'(1);
                        end
                    end
                end
                FLASH: begin
                    // A hit outranks a coincident frame tick.
                    if (collect_o) begin
                        state_q <= HIDDEN;
                        timer_q <= TIMER_W'(TIMEOUT_FRAMES);
                    end else if (frame_tick) begin
                        if (terminal) begin
                            state_q <= VISIBLE;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q - TIMER_W'(1);
                        end
                    end
                end
                DEAD: begin
                    state_q <= DEAD;
                end
                default: begin
                    state_q <= VISIBLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign show_o  = (state_q == VISIBLE) | ((state_q == FLASH) & flash_bit_i);
    assign value_o = digit_q;

endmodule

// File: rtl/number_slot_manager.sv
// -----------------------------------------------------------------------------
// number_slot_manager
// Owns SLOTS collectible digits: per-slot lifecycle, digit generation, score
// accumulation for the score block and the draw-request / colour merge for the
// VGA mux.
//
// Ports:
//   clk_i, reset_i    clock, synchronous active-high reset
//   enable_i          game running; low freezes timers, blink and hits
//   startOfFrame_i    one-clk pulse per VGA frame
//   hit_i             per-slot collision
//   slotDR_i          per-slot draw request from NUMBER_DISPLAY
//   slotRGB_i         per-slot colour, slot i at [8i+7:8i]
//   showNum_o         per-slot show flag to NUMBER_DISPLAY
//   digit_o           per-slot digit, slot i at [4i+3:4i]
//   anyDR_o           merged draw request (combinational)
//   rgbOut_o          merged colour, lowest drawing slot wins (combinational)
//   scoreValid_o      one-clk pulse when at least one slot was collected
//   scoreAdd_o        sum of the digits collected in that cycle
// -----------------------------------------------------------------------------
module number_slot_manager
    import number_slot_pkg::*;
#(
    parameter int         SLOTS          = 9,
    parameter int         TIMEOUT_FRAMES = 450,
    parameter int         FLASH_FRAMES   = 64,
    parameter int         TIMER_W        = 9,
    parameter int         ONE_SHOT       = 0,
    parameter int         DIGIT_MAX      = 9,
    parameter logic [7:0] LFSR_SEED      = 8'hA5,
    localparam int        SCORE_W        = $clog2(SLOTS * 16)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 startOfFrame_i,
    input  logic [SLOTS-1:0]     hit_i,
    input  logic [SLOTS-1:0]     slotDR_i,
    input  logic [SLOTS*8-1:0]   slotRGB_i,
    output logic [SLOTS-1:0]     showNum_o,
    output logic [SLOTS*4-1:0]   digit_o,
    output logic                 anyDR_o,
    output logic [7:0]           rgbOut_o,
    output logic                 scoreValid_o,
    output logic [SCORE_W-1:0]   scoreAdd_o
);

    logic [7:0]             lfsr_q, lfsr_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   score_valid_q, score_valid_d;
    logic [SCORE_W-1:0]     score_add_q, score_add_d;
    logic [SLOTS-1:0]       collect;
    logic [SLOTS-1:0]       drawing;
    logic                   flash_bit;

    // Free-running value generator; keeps stepping while the game is paused
    // so pauses do not make re-spawn values predictable.
    assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

    // Frame counter runs downward from 0, so the first frame after reset
    // lands on 4'hF and the blink starts in its "on" half.
    assign frame_d   = (enable_i & startOfFrame_i) ? (frame_q - FRAME_CNT_W'(1)) : frame_q;
    assign flash_bit = frame_q[3];

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic [3:0] cand_digit;

        // Rotating per slot keeps simultaneous re-spawns from all showing
        // the same value.
        assign cand_digit = lfsr_to_digit(rotl8(lfsr_q, 3'(i)), DIGIT_MAX);

        number_slot_ctrl #(
            .TIMEOUT_FRAMES (TIMEOUT_FRAMES),
            .FLASH_FRAMES   (FLASH_FRAMES),
            .TIMER_W        (TIMER_W),
            .ONE_SHOT       (ONE_SHOT),
            .RESET_DIGIT    (4'((i % DIGIT_MAX) + 1))
        ) u_slot (
            .clk_i            (clk_i),
            .reset_i          (reset_i),
            .enable_i         (enable_i),
            .start_of_frame_i (startOfFrame_i),
            .hit_i            (hit_i[i]),
            .flash_bit_i      (flash_bit),
            .cand_digit_i     (cand_digit),
            .show_o           (showNum_o[i]),
            .collect_o        (collect[i]),
            .value_o          (digit_o[i*4 +: 4])
        );
    end

    always_comb begin
        score_add_d   = '0;
        score_valid_d = |collect;
        for (int i = 0; i < SLOTS; i++) begin
            if (collect[i]) begin
                score_add_d = score_add_d + SCORE_W'(digit_o[i*4 +: 4]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q        <= LFSR_SEED;
            frame_q       <= '0;
            score_valid_q <= 1'b0;
            score_add_q   <= '0;
        end else begin
            lfsr_q        <= lfsr_d;
            frame_q       <= frame_d;
            score_valid_q <= score_valid_d;
            score_add_q   <= score_add_d;
        end
    end

    assign scoreValid_o = score_valid_q;
    assign scoreAdd_o   = score_add_q;

    assign drawing = slotDR_i & showNum_o;
    assign anyDR_o = |drawing;

    // Walk from the top so the lowest drawing index is the last assignment.
    always_comb begin
        rgbOut_o = TRANSPARENT_RGB;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (drawing[i]) begin
                rgbOut_o = slotRGB_i[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_number_slot_manager.sv
module tb_number_slot_manager;

    logic        clk = 1'b0;
    logic        reset, enable, sof;
    logic [8:0]  hit, hit_os, slot_dr;
    logic [71:0] slot_rgb;

    logic [8:0]  show, show_os;
    logic [35:0] digit, digit_os;
    logic        any_dr, any_dr_os, sv, sv_os;
    logic [7:0]  rgb, rgb_os, sa, sa_os;

    int passed = 0;
    int total  = 0;

    // Reference state: LFSR value and count of enabled frame pulses since reset.
    logic [7:0] lfsr_m, lfsr_prev;
    int         fc;
    logic [3:0] exp_d;

    always #5 clk = ~clk;

    number_slot_manager dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .startOfFrame_i(sof),
        .hit_i(hit), .slotDR_i(slot_dr), .slotRGB_i(slot_rgb),
        .showNum_o(show), .digit_o(digit), .anyDR_o(any_dr), .rgbOut_o(rgb),
        .scoreValid_o(sv), .scoreAdd_o(sa)
    );

    number_slot_manager #(.ONE_SHOT(1)) dut_os (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .startOfFrame_i(sof),
        .hit_i(hit_os), .slotDR_i(slot_dr), .slotRGB_i(slot_rgb),
        .showNum_o(show_os), .digit_o(digit_os), .anyDR_o(any_dr_os), .rgbOut_o(rgb_os),
        .scoreValid_o(sv_os), .scoreAdd_o(sa_os)
    );

    always @(posedge clk) begin
        lfsr_prev = lfsr_m;
        if (reset) begin
            lfsr_m = 8'hA5;
            fc     = 0;
        end else begin
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            if (sof && enable) fc = fc + 1;
        end
    end

    function automatic logic [3:0] model_digit(input logic [7:0] x, input int rot);
        logic [7:0] t;
        logic [4:0] v;
        t = x;
        for (int k = 0; k < (rot % 8); k++) t = {t[6:0], t[7]};
        v = {1'b0, t[3:0]};
        if (v > 5'd9) v = v - 5'd10;
        if (v == 5'd0) v = 5'd1;
        return v[3:0];
    endfunction

    // Blink phase: a down-counter from 0 after fc frames shows when its bit 3 is set.
    function automatic logic flash_on(input int n);
        return (((16 - (n % 16)) % 16) >= 8);
    endfunction

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            sof = 1'b1; tick();
            sof = 1'b0; tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; sof = 1'b0;
        hit = '0; hit_os = '0; slot_dr = '0;
        for (int i = 0; i < 9; i++) slot_rgb[i*8 +: 8] = 8'(8'h10 + i);
        tick(); tick();
        reset = 1'b0;

        // reset state
        check("rst_show", 36'(show), 36'h1FF);
        check("rst_digit", digit, 36'h987654321);
        check("rst_anydr", 36'(any_dr), 36'h0);
        check("rst_rgb", 36'(rgb), 36'hFF);
        check("rst_valid", 36'(sv), 36'h0);
        check("rst_add", 36'(sa), 36'h0);
        check("rst_os_show", 36'(show_os), 36'h1FF);

        // merge, exercised on the one-shot instance
        slot_dr = 9'h006; #1;
        check("mrg_any", 36'(any_dr_os), 36'h1);
        check("mrg_rgb1", 36'(rgb_os), 36'h11);
        check("mrg_main_rgb1", 36'(rgb), 36'h11);
        hit_os = 9'h002; tick(); hit_os = '0;
        check("os_add_slot1", 36'(sa_os), 36'h2);
        check("mrg_rgb2", 36'(rgb_os), 36'h12);
        hit_os = 9'h004; tick(); hit_os = '0;
        check("mrg_none_dr", 36'(any_dr_os), 36'h0);
        check("mrg_none_rgb", 36'(rgb_os), 36'hFF);
        slot_dr = '0;

        // single hit on slot 4 (digit 5)
        hit = 9'h010; tick(); hit = '0;
        check("hit4_show", 36'(show), 36'h1EF);
        check("hit4_valid", 36'(sv), 36'h1);
        check("hit4_add", 36'(sa), 36'h5);
        tick();
        check("hit4_pulse_end", 36'(sv), 36'h0);

        // slot 4 timeout and re-spawn
        frames(449);
        check("hit4_hidden449", 36'(show[4]), 36'h0);
        check("hit4_digit_hold", 36'(digit[19:16]), 36'h5);
        sof = 1'b1; tick();
        exp_d = model_digit(lfsr_prev, 4);
        check("resp4_digit", 36'(digit[19:16]), 36'(exp_d));
        check("resp4_range", 36'((digit[19:16] >= 4'd1) && (digit[19:16] <= 4'd9)), 36'h1);
        check("resp4_flash_on", 36'(show[4]), 36'h1);
        sof = 1'b0; tick();
        frames(7);
        check("resp4_flash_off", 36'(show[4]), 36'h0);
        frames(57);
        check("resp4_visible", 36'(show), 36'h1FF);

        // simultaneous hits 0,2,8 (digits 1,3,9), then hold hit[0]
        hit = 9'h105; tick();
        check("multi_valid", 36'(sv), 36'h1);
        check("multi_add", 36'(sa), 36'd13);
        check("multi_show", 36'(show & 9'h105), 36'h0);
        hit = 9'h001;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("hold_no_rescore", 36'(sv), 36'h0);
        end
        hit = '0;

        // hit on slot 1 coincident with a frame pulse
        hit = 9'h002; sof = 1'b1; tick(); hit = '0; sof = 1'b0;
        check("coinc_show", 36'(show[1]), 36'h0);
        check("coinc_valid", 36'(sv), 36'h1);
        check("coinc_add", 36'(sa), 36'h2);
        frames(200);

        // pause: hits dropped, 100 frames do not count
        enable = 1'b0;
        hit = 9'h008; tick(); hit = '0;
        check("dis_drop_valid", 36'(sv), 36'h0);
        check("dis_drop_show", 36'(show[3]), 36'h1);
        frames(100);
        enable = 1'b1; tick();
        check("dis_not_queued", 36'(sv), 36'h0);
        frames(248);

        // slots 0,2,8 re-spawn together; slot 1 still one frame short
        sof = 1'b1; tick();
        check("multi_resp_d0", 36'(digit[3:0]), 36'(model_digit(lfsr_prev, 0)));
        check("multi_resp_d2", 36'(digit[11:8]), 36'(model_digit(lfsr_prev, 2)));
        check("multi_resp_d8", 36'(digit[35:32]), 36'(model_digit(lfsr_prev, 8)));
        check("coinc_hidden449", 36'(show[1]), 36'h0);
        check("coinc_digit_hold", 36'(digit[7:4]), 36'h2);
        sof = 1'b0; tick();
        sof = 1'b1; tick();
        check("coinc_resp_digit", 36'(digit[7:4]), 36'(model_digit(lfsr_prev, 1)));
        check("coinc_resp_show", 36'(show[1]), 36'(flash_on(fc)));
        sof = 1'b0; tick();

        // one-shot: hit slot 3 stays dead
        hit_os = 9'h008; tick(); hit_os = '0;
        check("os_add_slot3", 36'(sa_os), 36'h4);
        frames(500);
        check("os_dead3", 36'(show_os[3]), 36'h0);
        check("os_dead12", 36'(show_os[2:1]), 36'h0);
        reset = 1'b1; tick();
        check("os_reset_show", 36'(show_os), 36'h1FF);
        check("reset2_show", 36'(show), 36'h1FF);
        check("reset2_digit", digit, 36'h987654321);
        check("reset2_valid", 36'(sv), 36'h0);
        reset = 1'b0; tick();
        check("reset2_no_pulse", 36'(sv), 36'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
